mem_port_master: RTL and testbench

- Initiator side of the 16-bit RISC core's unified memory.
- Arbitrates instruction-fetch and load/store requests from the pipeline onto the memory's two ports:
  - one combinational read port (raddr/rout);
  - one synchronous write port (wen/waddr/win).
- Adds registered, valid/ready-handshaked responses and a one-entry store buffer with store-to-load forwarding.
- Sits between the core's fetch/execute stages and the 4096x16 memory.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_store_buffer.sv | 63 ++++++
 rtl/mem_port_master.sv | 109 ++++++++++
 tb/tb_mem_port_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the core's unified-memory initiator: widths, opcodes,
// and the store-buffer entry layout.
package mem_pkg;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LD  = 4'd1,
        OP_ST  = 4'd2,
        OP_LDI = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_AND = 4'd6,
        OP_OR  = 4'd7,
        OP_XOR = 4'd8,
        OP_NOT = 4'd9,
        OP_SHL = 4'd10,
        OP_SHR = 4'd11,
        OP_BR  = 4'd12
    } opcode_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    typedef enum logic {
        SB_EMPTY = 1'b0,
        SB_FULL  = 1'b1
    } sb_state_t;

    function automatic logic sb_hit(input sb_entry_t e, input logic [AW-1:0] a);
        return e.valid && (e.addr == a);
    endfunction

endpackage

// File: rtl/mem_store_buffer.sv
// One-entry store buffer: captures an accepted store, drains it to the memory
// write port on the following cycle, and answers forwarding lookups meanwhile.
module mem_store_buffer
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_st_accept,
    input  logic [AW-1:0] i_st_addr,
    input  logic [DW-1:0] i_st_data,
    input  logic [AW-1:0] i_fwd_addr_d,
    input  logic [AW-1:0] i_fwd_addr_if,
    output logic          o_hit_d,
    output logic          o_hit_if,
    output logic [DW-1:0] o_fwd_data,
    output logic          o_wen,
    output logic [AW-1:0] o_waddr,
    output logic [DW-1:0] o_win
);

    sb_state_t     r_state;
    sb_state_t     w_state_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    sb_entry_t     w_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SB_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (i_st_accept) begin
            r_addr <= i_st_addr;
            r_data <= i_st_data;
        end
    end

    // The entry drains every cycle it is full, so only a fresh accept keeps it full.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SB_EMPTY: if (i_st_accept) w_state_next = SB_FULL;
            SB_FULL:  w_state_next = i_st_accept ? SB_FULL : SB_EMPTY;
            default:  w_state_next = SB_EMPTY;
        endcase
    end

    assign w_entry    = '{valid: (r_state == SB_FULL), addr: r_addr, data: r_data};
    assign o_hit_d    = sb_hit(w_entry, i_fwd_addr_d);
    assign o_hit_if   = sb_hit(w_entry, i_fwd_addr_if);
    assign o_fwd_data = w_entry.data;
    assign o_wen      = w_entry.valid;
    assign o_waddr    = w_entry.addr;
    assign o_win      = w_entry.data;

endmodule

// File: rtl/mem_port_master.sv
// Arbitrates fetch and load/store traffic onto the memory's combinational read
// port and synchronous write port, with registered valid/ready responses.
module mem_port_master #(
    parameter int AW = mem_pkg::AW,
    parameter int DW = mem_pkg::DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    input  logic          if_rsp_ready,
    output logic [DW-1:0] if_rsp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    input  logic          d_rsp_ready,
    output logic [DW-1:0] d_rsp_data,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rout,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] win
);

    logic          r_if_rsp_valid;
    logic [DW-1:0] r_if_rsp_data;
    logic          r_d_rsp_valid;
    logic [DW-1:0] r_d_rsp_data;
    logic [AW-1:0] r_raddr_hold;

    logic          w_d_load_ok;
    logic          w_if_ok;
    logic          w_if_accept;
    logic          w_st_accept;
    logic          w_hit_d;
    logic          w_hit_if;
    logic [DW-1:0] w_fwd_data;
    logic [AW-1:0] w_raddr;

    assign w_d_load_ok = d_req_valid & ~d_req_we & (~r_d_rsp_valid | d_rsp_ready);
    assign w_if_ok     = if_req_valid & (~r_if_rsp_valid | if_rsp_ready);
    assign w_if_accept = w_if_ok & ~w_d_load_ok;
    assign w_st_accept = d_req_valid & d_req_we;

    // Loads win the single read port; an idle cycle keeps the previous address.
    always_comb begin
        w_raddr = r_raddr_hold;
        if (w_d_load_ok) begin
            w_raddr = d_req_addr;
        end else if (w_if_ok) begin
            w_raddr = if_req_addr;
        end
    end

    assign raddr        = w_raddr;
    assign if_req_ready = w_if_accept;
    assign d_req_ready  = d_req_we ? 1'b1 : w_d_load_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_raddr_hold   <= '0;
            r_d_rsp_valid  <= 1'b0;
            r_d_rsp_data   <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
        end else begin
            r_raddr_hold <= w_raddr;
            if (w_d_load_ok) begin
                r_d_rsp_valid <= 1'b1;
                r_d_rsp_data  <= w_hit_d ? w_fwd_data : rout;
            end else if (d_rsp_ready) begin
                r_d_rsp_valid <= 1'b0;
            end
            if (w_if_accept) begin
                r_if_rsp_valid <= 1'b1;
                r_if_rsp_data  <= w_hit_if ? w_fwd_data : rout;
            end else if (if_rsp_ready) begin
                r_if_rsp_valid <= 1'b0;
            end
        end
    end

    assign d_rsp_valid  = r_d_rsp_valid;
    assign d_rsp_data   = r_d_rsp_data;
    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_data  = r_if_rsp_data;

    mem_store_buffer u_store_buffer (
        .clk          (clock),
        .rst          (reset),
        .i_st_accept  (w_st_accept),
        .i_st_addr    (d_req_addr),
        .i_st_data    (d_req_wdata),
        .i_fwd_addr_d (d_req_addr),
        .i_fwd_addr_if(if_req_addr),
        .o_hit_d      (w_hit_d),
        .o_hit_if     (w_hit_if),
        .o_fwd_data   (w_fwd_data),
        .o_wen        (wen),
        .o_waddr      (waddr),
        .o_win        (win)
    );

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a behavioural 4096x16 memory attached.
module tb_mem_port_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [11:0] if_req_addr = '0;
    logic        if_rsp_valid;
    logic        if_rsp_ready = 1'b0;
    logic [15:0] if_rsp_data;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic        d_req_we = 1'b0;
    logic [11:0] d_req_addr = '0;
    logic [15:0] d_req_wdata = '0;
    logic        d_rsp_valid;
    logic        d_rsp_ready = 1'b0;
    logic [15:0] d_rsp_data;
    logic [11:0] raddr;
    logic [15:0] rout;
    logic        wen;
    logic [11:0] waddr;
    logic [15:0] win;

    logic [15:0] mem [0:4095];
    logic        mem_loaded = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    // Memory image: mem[i]=i except a short program at 0..2.
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
            mem[0] <= 16'h1005;
            mem[1] <= 16'h2006;
            mem[2] <= 16'hC000;
            mem_loaded <= 1'b1;
        end else if (wen) begin
            mem[waddr] <= win;
        end
    end
    assign rout = mem[raddr];

    mem_port_master dut (
        .clock       (clock),
        .reset       (reset),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_req_addr (if_req_addr),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_ready(if_rsp_ready),
        .if_rsp_data (if_rsp_data),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_we    (d_req_we),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_ready (d_rsp_ready),
        .d_rsp_data  (d_rsp_data),
        .raddr       (raddr),
        .rout        (rout),
        .wen         (wen),
        .waddr       (waddr),
        .win         (win)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst_if_rsp_data", 32'(if_rsp_data), 32'd0);
        chk("rst_d_rsp_data", 32'(d_rsp_data), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        reset = 1'b0;
        tick();

        // Fetch stream 0,1,2
        if_rsp_ready = 1'b1;
        d_rsp_ready  = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 12'd0;
        #1;
        chk("fetch0_ready", 32'(if_req_ready), 32'd1);
        chk("fetch0_raddr", 32'(raddr), 32'd0);
        tick();
        chk("fetch0_valid", 32'(if_rsp_valid), 32'd1);
        chk("fetch0_data", 32'(if_rsp_data), 32'h1005);
        if_req_addr = 12'd1;
        tick();
        chk("fetch1_valid", 32'(if_rsp_valid), 32'd1);
        chk("fetch1_data", 32'(if_rsp_data), 32'h2006);
        if_req_addr = 12'd2;
        tick();
        chk("fetch2_valid", 32'(if_rsp_valid), 32'd1);
        chk("fetch2_data", 32'(if_rsp_data), 32'hC000);
        if_req_valid = 1'b0;
        tick();
        chk("fetch_drain_valid", 32'(if_rsp_valid), 32'd0);

        // Load vs fetch conflict
        if_req_valid = 1'b1;
        if_req_addr  = 12'd5;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_addr   = 12'd20;
        #1;
        chk("conf_d_ready", 32'(d_req_ready), 32'd1);
        chk("conf_if_stalled", 32'(if_req_ready), 32'd0);
        chk("conf_raddr_load", 32'(raddr), 32'd20);
        tick();
        chk("conf_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        chk("conf_d_rsp_data", 32'(d_rsp_data), 32'd20);
        chk("conf_if_rsp_idle", 32'(if_rsp_valid), 32'd0);
        d_req_valid = 1'b0;
        #1;
        chk("conf_if_ready", 32'(if_req_ready), 32'd1);
        chk("conf_raddr_fetch", 32'(raddr), 32'd5);
        tick();
        chk("conf_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        chk("conf_if_rsp_data", 32'(if_rsp_data), 32'd5);
        chk("conf_d_rsp_clear", 32'(d_rsp_valid), 32'd0);
        if_req_valid = 1'b0;
        tick();

        // Store then load, same address
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 12'd22;
        d_req_wdata = 16'h1234;
        #1;
        chk("st_ready", 32'(d_req_ready), 32'd1);
        tick();
        d_req_we = 1'b0;
        #1;
        chk("st_wen", 32'(wen), 32'd1);
        chk("st_waddr", 32'(waddr), 32'd22);
        chk("st_win", 32'(win), 32'h1234);
        chk("st_mem_stale", 32'(mem[22]), 32'd22);
        chk("fwd_ld_ready", 32'(d_req_ready), 32'd1);
        tick();
        d_req_valid = 1'b0;
        chk("fwd_d_rsp_data", 32'(d_rsp_data), 32'h1234);
        chk("fwd_wen_off", 32'(wen), 32'd0);
        chk("fwd_mem_written", 32'(mem[22]), 32'h1234);
        tick();

        // Back-to-back stores 30,31,32
        for (int i = 0; i < 3; i++) begin
            d_req_valid = 1'b1;
            d_req_we    = 1'b1;
            d_req_addr  = 12'(30 + i);
            d_req_wdata = 16'(16'hC000 + i);
            #1;
            chk("b2b_ready", 32'(d_req_ready), 32'd1);
            tick();
            chk("b2b_wen", 32'(wen), 32'd1);
            chk("b2b_waddr", 32'(waddr), 32'(30 + i));
            chk("b2b_win", 32'(win), 32'(16'hC000 + i));
        end
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        tick();
        chk("b2b_wen_off", 32'(wen), 32'd0);
        chk("b2b_mem30", 32'(mem[30]), 32'hC000);
        chk("b2b_mem31", 32'(mem[31]), 32'hC001);
        chk("b2b_mem32", 32'(mem[32]), 32'hC002);

        // Response backpressure
        d_rsp_ready = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 12'd12;
        #1;
        chk("bp_ld_ready", 32'(d_req_ready), 32'd1);
        tick();
        d_req_addr = 12'd13;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_second_blocked", 32'(d_req_ready), 32'd0);
            chk("bp_raddr_hold", 32'(raddr), 32'd12);
            tick();
            chk("bp_rsp_valid", 32'(d_rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(d_rsp_data), 32'd12);
        end
        d_rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(d_req_ready), 32'd1);
        tick();
        d_req_valid = 1'b0;
        chk("bp_replace_valid", 32'(d_rsp_valid), 32'd1);
        chk("bp_replace_data", 32'(d_rsp_data), 32'd13);
        tick();
        chk("bp_consumed", 32'(d_rsp_valid), 32'd0);

        // Reset mid-operation with a load response held and a store buffered
        d_rsp_ready = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 12'd12;
        tick();
        d_req_we    = 1'b1;
        d_req_addr  = 12'd40;
        d_req_wdata = 16'hBEEF;
        tick();
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        chk("mid_pre_d_valid", 32'(d_rsp_valid), 32'd1);
        chk("mid_pre_wen", 32'(wen), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("mid_d_rsp_data", 32'(d_rsp_data), 32'd0);
        chk("mid_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        chk("mid_wen", 32'(wen), 32'd0);
        chk("mid_waddr", 32'(waddr), 32'd0);
        chk("mid_win", 32'(win), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("mid_store_dropped", 32'(mem[40]), 32'd40);
        chk("mid_wen_after", 32'(wen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
